// File: rtl/tilelink_nto1_arbiter_if.sv
// Bus bundle for the N-to-1 TileLink-UH arbiter.
// Per-master A/D signals are packed vectors with master i occupying slice i.
// Modport slave  : the arbiter's view (accepts master A, drives slave A, routes D back).
// Modport master : the surrounding environment's view (masters plus the downstream slave).
interface tilelink_nto1_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SIZE_W      = 4,
    parameter int unsigned SRC_W       = 4,
    parameter int unsigned IDX_W       = $clog2(NUM_MASTERS)
);
    localparam int unsigned N      = NUM_MASTERS;
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned SSRC_W = SRC_W + IDX_W;

    // master-side A channel
    logic [3*N-1:0]      master_a_opcode;
    logic [3*N-1:0]      master_a_param;
    logic [SIZE_W*N-1:0] master_a_size;
    logic [SRC_W*N-1:0]  master_a_source;
    logic [ADDR_W*N-1:0] master_a_address;
    logic [MASK_W*N-1:0] master_a_mask;
    logic [DATA_W*N-1:0] master_a_data;
    logic [N-1:0]        master_a_corrupt;
    logic [N-1:0]        master_a_valid;
    logic [N-1:0]        master_a_ready;

    // master-side D channel
    logic [3*N-1:0]      master_d_opcode;
    logic [2*N-1:0]      master_d_param;
    logic [SIZE_W*N-1:0] master_d_size;
    logic [SRC_W*N-1:0]  master_d_source;
    logic [N-1:0]        master_d_denied;
    logic [N-1:0]        master_d_corrupt;
    logic [N-1:0]        master_d_valid;
    logic [DATA_W*N-1:0] master_d_data;
    logic [N-1:0]        master_d_ready;

    // slave-side A channel
    logic [2:0]          slave_a_opcode;
    logic [2:0]          slave_a_param;
    logic [SIZE_W-1:0]   slave_a_size;
    logic [SSRC_W-1:0]   slave_a_source;
    logic [ADDR_W-1:0]   slave_a_address;
    logic [MASK_W-1:0]   slave_a_mask;
    logic [DATA_W-1:0]   slave_a_data;
    logic                slave_a_corrupt;
    logic                slave_a_valid;
    logic                slave_a_ready;

    // slave-side D channel
    logic [2:0]          slave_d_opcode;
    logic [1:0]          slave_d_param;
    logic [SIZE_W-1:0]   slave_d_size;
    logic [SSRC_W-1:0]   slave_d_source;
    logic                slave_d_denied;
    logic                slave_d_corrupt;
    logic                slave_d_valid;
    logic [DATA_W-1:0]   slave_d_data;
    logic                slave_d_ready;

    modport slave (
        input  master_a_opcode, master_a_param, master_a_size, master_a_source,
               master_a_address, master_a_mask, master_a_data, master_a_corrupt,
               master_a_valid, master_d_ready, slave_a_ready,
               slave_d_opcode, slave_d_param, slave_d_size, slave_d_source,
               slave_d_denied, slave_d_corrupt, slave_d_valid, slave_d_data,
        output master_a_ready,
               master_d_opcode, master_d_param, master_d_size, master_d_source,
               master_d_denied, master_d_corrupt, master_d_valid, master_d_data,
               slave_a_opcode, slave_a_param, slave_a_size, slave_a_source,
               slave_a_address, slave_a_mask, slave_a_data, slave_a_corrupt,
               slave_a_valid, slave_d_ready
    );

    modport master (
        output master_a_opcode, master_a_param, master_a_size, master_a_source,
               master_a_address, master_a_mask, master_a_data, master_a_corrupt,
               master_a_valid, master_d_ready, slave_a_ready,
               slave_d_opcode, slave_d_param, slave_d_size, slave_d_source,
               slave_d_denied, slave_d_corrupt, slave_d_valid, slave_d_data,
        input  master_a_ready,
               master_d_opcode, master_d_param, master_d_size, master_d_source,
               master_d_denied, master_d_corrupt, master_d_valid, master_d_data,
               slave_a_opcode, slave_a_param, slave_a_size, slave_a_source,
               slave_a_address, slave_a_mask, slave_a_data, slave_a_corrupt,
               slave_a_valid, slave_d_ready
    );
endinterface

// File: rtl/tilelink_nto1_arbiter.sv
// N-to-1 TileLink-UH arbiter: round-robin on channel A with multi-beat data
// messages locked to one master, master index prefixed onto a_source, and
// D responses routed back by the upper source bits.
// Ports: tilelink_clock_i (rising edge), tilelink_reset_i (async, active-low),
//        bus (tilelink_nto1_arbiter_if.slave) carrying all A/D channel signals.
module tilelink_nto1_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SIZE_W      = 4,
    parameter int unsigned SRC_W       = 4,
    parameter int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                          tilelink_clock_i,
    input  logic                          tilelink_reset_i,
    tilelink_nto1_arbiter_if.slave        bus
);
    localparam int unsigned N        = NUM_MASTERS;
    localparam int unsigned MASK_W   = DATA_W / 8;
    localparam int unsigned SSRC_W   = SRC_W + IDX_W;
    localparam int unsigned LG_BYTES = $clog2(MASK_W);
    localparam int unsigned CNT_W    = 2 ** SIZE_W;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [2:0]        param;
        logic [SIZE_W-1:0] size;
        logic [SSRC_W-1:0] source;
        logic [ADDR_W-1:0] address;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] data;
        logic              corrupt;
    } a_beat_t;

    typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

    state_t            state_q,    state_d;
    logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]  rr_ptr_q,   rr_ptr_d;
    logic              a_valid_q;
    a_beat_t           a_beat_q;

    logic              found_c;
    logic [IDX_W-1:0]  gidx_c;
    logic [IDX_W-1:0]  cand_c;
    logic [N-1:0]      grant_c;
    logic              adv_c;
    logic              acc_c;
    a_beat_t           nxt_beat_c;
    logic              multi_c;
    logic [CNT_W-1:0]  first_cnt_c;
    logic              last_beat_c;
    int unsigned       sel_c;
    logic [IDX_W-1:0]  d_idx_c;

    // Grant: the locked master, else first valid master from rr_ptr onward.
    always_comb begin
        found_c = 1'b0;
        gidx_c  = '0;
        cand_c  = '0;
        if (state_q == ST_LOCKED) begin
            found_c = 1'b1;
            gidx_c  = lock_idx_q;
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                cand_c = IDX_W'((32'(rr_ptr_q) + k) % N);
                if (!found_c && bus.master_a_valid[cand_c]) begin
                    found_c = 1'b1;
                    gidx_c  = cand_c;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            grant_c[i] = found_c && (gidx_c == IDX_W'(i));
        end
    end

    assign adv_c              = !a_valid_q || bus.slave_a_ready;
    assign bus.master_a_ready = grant_c & {N{adv_c}};
    assign acc_c              = found_c && bus.master_a_valid[gidx_c] && adv_c;

    // Payload of the granted master, with its index prefixed onto the source.
    always_comb begin
        sel_c              = 32'(gidx_c);
        nxt_beat_c.opcode  = bus.master_a_opcode[sel_c*3 +: 3];
        nxt_beat_c.param   = bus.master_a_param[sel_c*3 +: 3];
        nxt_beat_c.size    = bus.master_a_size[sel_c*SIZE_W +: SIZE_W];
        nxt_beat_c.source  = {gidx_c, bus.master_a_source[sel_c*SRC_W +: SRC_W]};
        nxt_beat_c.address = bus.master_a_address[sel_c*ADDR_W +: ADDR_W];
        nxt_beat_c.mask    = bus.master_a_mask[sel_c*MASK_W +: MASK_W];
        nxt_beat_c.data    = bus.master_a_data[sel_c*DATA_W +: DATA_W];
        nxt_beat_c.corrupt = bus.master_a_corrupt[gidx_c];
    end

    // Data opcodes (0..3) larger than one beat lock the port; the counter
    // starts at beats-2 because the first beat is consumed on the lock cycle.
    assign multi_c     = !nxt_beat_c.opcode[2] && (nxt_beat_c.size > SIZE_W'(LG_BYTES));
    assign first_cnt_c = (CNT_W'(1) << (nxt_beat_c.size - SIZE_W'(LG_BYTES))) - CNT_W'(2);

    // Lock / beat-count / round-robin next state.
    always_comb begin
        state_d     = state_q;
        lock_idx_d  = lock_idx_q;
        beat_cnt_d  = beat_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        last_beat_c = 1'b0;
        case (state_q)
            ST_OPEN: begin
                if (acc_c) begin
                    if (multi_c) begin
                        state_d    = ST_LOCKED;
                        lock_idx_d = gidx_c;
                        beat_cnt_d = first_cnt_c;
                    end else begin
                        last_beat_c = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (acc_c) begin
                    if (beat_cnt_q == '0) begin
                        state_d     = ST_OPEN;
                        last_beat_c = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_OPEN;
        endcase
        if (last_beat_c) begin
            rr_ptr_d = (gidx_c == IDX_W'(N - 1)) ? '0 : gidx_c + IDX_W'(1);
        end
    end

    // Arbitration state registers.
    always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_i) begin
        if (!tilelink_reset_i) begin
            state_q    <= ST_OPEN;
            lock_idx_q <= '0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // A output slice: valid flag.
    always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_i) begin
        if (!tilelink_reset_i) begin
            a_valid_q <= 1'b0;
        end else if (acc_c) begin
            a_valid_q <= 1'b1;
        end else if (bus.slave_a_ready) begin
            a_valid_q <= 1'b0;
        end
    end

    // A output slice: payload (no reset needed, qualified by valid).
    always_ff @(posedge tilelink_clock_i) begin
        if (acc_c) begin
            a_beat_q <= nxt_beat_c;
        end
    end

    assign bus.slave_a_valid   = a_valid_q;
    assign bus.slave_a_opcode  = a_beat_q.opcode;
    assign bus.slave_a_param   = a_beat_q.param;
    assign bus.slave_a_size    = a_beat_q.size;
    assign bus.slave_a_source  = a_beat_q.source;
    assign bus.slave_a_address = a_beat_q.address;
    assign bus.slave_a_mask    = a_beat_q.mask;
    assign bus.slave_a_data    = a_beat_q.data;
    assign bus.slave_a_corrupt = a_beat_q.corrupt;

    // D routing: index from upper source bits; unmapped indices are sunk.
    assign d_idx_c = bus.slave_d_source[SSRC_W-1:SRC_W];

    always_comb begin
        bus.slave_d_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.master_d_valid[i]                  = bus.slave_d_valid && (d_idx_c == IDX_W'(i));
            bus.master_d_opcode[i*3 +: 3]          = bus.slave_d_opcode;
            bus.master_d_param[i*2 +: 2]           = bus.slave_d_param;
            bus.master_d_size[i*SIZE_W +: SIZE_W]  = bus.slave_d_size;
            bus.master_d_source[i*SRC_W +: SRC_W]  = bus.slave_d_source[SRC_W-1:0];
            bus.master_d_denied[i]                 = bus.slave_d_denied;
            bus.master_d_corrupt[i]                = bus.slave_d_corrupt;
            bus.master_d_data[i*DATA_W +: DATA_W]  = bus.slave_d_data;
            if (d_idx_c == IDX_W'(i)) begin
                bus.slave_d_ready = bus.master_d_ready[i];
            end
        end
    end
endmodule
